note_sequencer: RTL and testbench
=================================

# note_sequencer

Plays one note at a time from a valid/ready note stream. Each accepted note sets a square-wave half-period in clock cycles and a duration in time-base ticks. The block drives the speaker line, then inserts a fixed silent gap. It sits between the song/note source, which supplies the stream, and the speaker output pin. It is the consumer and controller of loadable down-counters: it issues load/value and reacts to each counter's zero condition.

## Interface
- GAP_TICKS, default 1: silent ticks after each note (0–255; 0 means no gap).
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_val  input  1  note valid.
- in_rdy  output  1  block can accept a note; high only in IDLE.
- in_period  input  8  half-period P; 0 means rest (silent note).
- in_dur  input  8  duration D in ticks; 0 means 256 ticks.
- tick  input  1  one-cycle time-base strobe for duration and gap counting.
- spk  output  1  square-wave speaker drive; registered.
- busy  output  1  high in PLAY or GAP.
- note_done  output  1  one-cycle pulse when a note and its gap are complete.

## Operation
- Reset values: state=IDLE, spk=0, in_rdy=1, busy=0, note_done=0, all counters 0.
- States and transitions:
  - IDLE → PLAY on `in_val && in_rdy`. Capture P into the period register and the half-period counter. Load D into the duration counter.
  - PLAY → GAP on `tick` when dcnt==1. If GAP_TICKS==0, go to IDLE instead.
  - GAP → IDLE on `tick` when gcnt==1.
- Half-period counter (PLAY only, P≠0):
  - If hcnt==0: toggle spk and reload hcnt=P.
  - Otherwise: hcnt=hcnt−1.
- P==0: spk held 0 for the whole note; duration still counts.
- Duration counter:
  - Decrements on `tick` in PLAY.
  - Loaded value D is 8-bit; D==0 wraps, giving 256 ticks.
- Gap counter:
  - Loaded with GAP_TICKS on PLAY→GAP.
  - Decrements on `tick` in GAP.
- Leaving PLAY forces spk=0 on the same edge. spk is 0 in GAP and IDLE.
- note_done:
  - Registered.
  - High exactly in the first IDLE cycle after a note's gap ends (or after PLAY ends when GAP_TICKS==0).
- No buffering: a new note is accepted only in IDLE. The stall is expressed via in_rdy=0.
- in_val while not ready: ignored; the source must hold it.
- Input data is sampled only on the accept edge.

## Timing
- Accept at edge E0. Cycle 1 after E0: state=PLAY, hcnt=P, spk=0.
- First spk rise is visible at cycle P+2 after E0.
- Half-period is P+1 cycles; full period is 2(P+1) cycles.
- tick in the accept cycle is ignored; counting starts the cycle after accept.
- Note length is D ticks, counted from the first tick seen in PLAY.
- Simultaneous hcnt==0 and final duration tick: the end-of-note wins and spk goes to 0.
- in_rdy rises in the same cycle note_done is high. A note can be accepted in that cycle.
- Back-to-back notes: at most one idle cycle between a gap's end and the next PLAY.
- rst mid-PLAY or mid-GAP:
  - Next cycle state=IDLE, spk=0.
  - No note_done pulse.
  - Pending note is discarded.
- rst has priority over in_val and tick.

## Structure
- Package `note_sequencer_pkg`:
  - State enum {IDLE, PLAY, GAP} (2-bit).
  - PERIOD_W=8, DUR_W=8 (DUR_W wide enough for the 256-tick case: counter is 9-bit internally).
- One sub-module `note_down_counter`: 9-bit loadable down-counter with load, dec enable, and zero/one flags.
  - Three instances: half-period, duration, gap.
- FSM and spk register live in the top block.

## Test plan
- Reset then note P=3, D=2, tick every 20 cycles, GAP_TICKS=1:
  - spk period 8 cycles, first rise at cycle 5.
  - spk=0 after the 2nd tick.
  - note_done is one cycle after the gap tick.
- Rest note P=0, D=3: spk stays 0 throughout; busy high for 3 ticks plus the gap; note_done pulses once.
- D=0, P=1, tick every cycle: PLAY lasts exactly 256 ticks; spk toggles every 2 cycles.
- Back-to-back (in_val held high, 3 notes, GAP_TICKS=0): each note accepted in its note_done cycle; in_rdy=0 throughout PLAY.
- rst asserted mid-PLAY with spk=1: next cycle spk=0, state IDLE, in_rdy=1, no note_done.
- Tick coincident with hcnt==0 on the last duration tick: spk goes to 0, not toggled high.

Source files
------------

// File: rtl/note_sequencer_pkg.sv
// Shared types and widths for the note sequencer and its down-counters.
// Duration counters are one bit wider than the note field so D==0 can mean 256 ticks.
package note_sequencer_pkg;

  localparam int PERIOD_W = 8;
  localparam int DUR_W    = 8;
  localparam int CNT_W    = DUR_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

  // A zero duration field encodes the maximum length of 2**DUR_W ticks.
  function automatic logic [CNT_W-1:0] dur_ticks(input logic [DUR_W-1:0] d);
    return (d == '0) ? CNT_W'(1 << DUR_W) : CNT_W'(d);
  endfunction

endpackage

// File: rtl/note_down_counter.sv
// Loadable down-counter with zero/one flags; load wins over decrement, holds at zero.
// Flags are combinational from the registered count; no backpressure.
module note_down_counter
  import note_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o,
  output logic             one_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);
  assign one_o  = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/note_sequencer.sv
// Plays one note (square wave for D ticks) then a fixed silent gap; spk and note_done registered.
// Accepts a note only in IDLE (in_rdy); the source holds in_val until then.
module note_sequencer
  import note_sequencer_pkg::*;
#(
  parameter int unsigned GAP_TICKS = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_val,
  output logic                in_rdy,
  input  logic [PERIOD_W-1:0] in_period,
  input  logic [DUR_W-1:0]    in_dur,
  input  logic                tick,
  output logic                spk,
  output logic                busy,
  output logic                note_done
);

  state_t              state_q, state_d;
  logic                spk_q, spk_d;
  logic                note_done_q, note_done_d;
  logic [PERIOD_W-1:0] period_q, period_d;

  logic             h_load, h_dec, h_zero, h_one_unused;
  logic [CNT_W-1:0] h_load_val;
  logic             d_load, d_dec, d_one, d_zero_unused;
  logic             g_load, g_dec, g_one, g_zero_unused;

  always_comb begin
    state_d     = state_q;
    spk_d       = spk_q;
    note_done_d = 1'b0;
    period_d    = period_q;
    h_load      = 1'b0;
    h_load_val  = CNT_W'(period_q);
    h_dec       = 1'b0;
    d_load      = 1'b0;
    d_dec       = 1'b0;
    g_load      = 1'b0;
    g_dec       = 1'b0;

    case (state_q)
      IDLE: begin
        spk_d = 1'b0;
        if (in_val && in_rdy) begin
          state_d    = PLAY;
          period_d   = in_period;
          h_load     = 1'b1;
          h_load_val = CNT_W'(in_period);
          d_load     = 1'b1;
        end
      end
      PLAY: begin
        if (period_q == '0) begin
          spk_d = 1'b0;
        end else if (h_zero) begin
          spk_d  = ~spk_q;
          h_load = 1'b1;
        end else begin
          h_dec = 1'b1;
        end
        // The final duration tick overrides any half-period toggle above.
        if (tick) begin
          if (d_one) begin
            spk_d  = 1'b0;
            g_load = 1'b1;
            if (GAP_TICKS == 0) begin
              state_d     = IDLE;
              note_done_d = 1'b1;
            end else begin
              state_d = GAP;
            end
          end else begin
            d_dec = 1'b1;
          end
        end
      end
      GAP: begin
        spk_d = 1'b0;
        if (tick) begin
          if (g_one) begin
            state_d     = IDLE;
            note_done_d = 1'b1;
          end else begin
            g_dec = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        spk_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      spk_q       <= 1'b0;
      note_done_q <= 1'b0;
      period_q    <= '0;
    end else begin
      state_q     <= state_d;
      spk_q       <= spk_d;
      note_done_q <= note_done_d;
      period_q    <= period_d;
    end
  end

  note_down_counter u_half (
    .clk       (clk),
    .rst       (rst),
    .load_i    (h_load),
    .load_val_i(h_load_val),
    .dec_i     (h_dec),
    .zero_o    (h_zero),
    .one_o     (h_one_unused)
  );

  note_down_counter u_dur (
    .clk       (clk),
    .rst       (rst),
    .load_i    (d_load),
    .load_val_i(dur_ticks(in_dur)),
    .dec_i     (d_dec),
    .zero_o    (d_zero_unused),
    .one_o     (d_one)
  );

  note_down_counter u_gap (
    .clk       (clk),
    .rst       (rst),
    .load_i    (g_load),
    .load_val_i(CNT_W'(GAP_TICKS)),
    .dec_i     (g_dec),
    .zero_o    (g_zero_unused),
    .one_o     (g_one)
  );

  assign in_rdy    = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign spk       = spk_q;
  assign note_done = note_done_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: two instances (gap of 1 tick and no gap) checked against a timeline model.
module tb_note_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_val, a_tick, a_rdy, a_spk, a_busy, a_done;
  logic [7:0] a_per, a_dur;
  logic       b_val, b_tick, b_rdy, b_spk, b_busy, b_done;
  logic [7:0] b_per, b_dur;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  note_sequencer #(.GAP_TICKS(1)) dut_a (
    .clk(clk), .rst(rst), .in_val(a_val), .in_rdy(a_rdy), .in_period(a_per),
    .in_dur(a_dur), .tick(a_tick), .spk(a_spk), .busy(a_busy), .note_done(a_done)
  );

  note_sequencer #(.GAP_TICKS(0)) dut_b (
    .clk(clk), .rst(rst), .in_val(b_val), .in_rdy(b_rdy), .in_period(b_per),
    .in_dur(b_dur), .tick(b_tick), .spk(b_spk), .busy(b_busy), .note_done(b_done)
  );

  // Model: phase 0 idle, 1 playing, 2 gap; k counts edges since the accept edge.
  typedef struct packed {
    int   phase;
    int   k;
    int   p;
    int   left;
    logic done;
  } model_t;

  model_t ma, mb;

  function automatic model_t step(model_t m, int gap, logic r, logic v,
                                  logic [7:0] per, logic [7:0] dur, logic t);
    model_t n;
    n = m;
    n.done = 1'b0;
    if (r) begin
      n.phase = 0;
      return n;
    end
    case (m.phase)
      0: if (v) begin
        n.phase = 1;
        n.k     = 0;
        n.p     = int'(per);
        n.left  = (dur == 8'd0) ? 256 : int'(dur);
      end
      1: begin
        n.k = m.k + 1;
        if (t) begin
          n.left = m.left - 1;
          if (n.left == 0) begin
            if (gap == 0) begin
              n.phase = 0;
              n.done  = 1'b1;
            end else begin
              n.phase = 2;
              n.left  = gap;
            end
          end
        end
      end
      default: if (t) begin
        n.left = m.left - 1;
        if (n.left == 0) begin
          n.phase = 0;
          n.done  = 1'b1;
        end
      end
    endcase
    return n;
  endfunction

  // Expected {spk, busy, in_rdy, note_done}; the wave is high in odd half-periods of P+1 edges.
  function automatic logic [3:0] expect_of(model_t m);
    logic s;
    s = (m.phase == 1) && (m.p != 0) && (((m.k / (m.p + 1)) % 2) == 1);
    return {s, m.phase != 0, m.phase == 0, m.done};
  endfunction

  always @(posedge clk) begin
    ma = step(ma, 1, rst, a_val, a_per, a_dur, a_tick);
    mb = step(mb, 0, rst, b_val, b_per, b_dur, b_tick);
  end

  task automatic idle_inputs();
    a_val = 0; a_tick = 0; a_per = 0; a_dur = 0;
    b_val = 0; b_tick = 0; b_per = 0; b_dur = 0;
  endtask

  task automatic test_reset();
    logic [3:0] oa, ob;
    rst = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clk);
    oa = {a_spk, a_busy, a_rdy, a_done};
    ob = {b_spk, b_busy, b_rdy, b_done};
    n_checks++;
    if (oa !== 4'b0010) begin n_fail++; $display("FAIL reset_a got=%b want=0010", oa); end
    n_checks++;
    if (ob !== 4'b0010) begin n_fail++; $display("FAIL reset_b got=%b want=0010", ob); end
    rst = 1'b0;
    @(negedge clk);
    oa = {a_spk, a_busy, a_rdy, a_done};
    n_checks++;
    if (oa !== expect_of(ma)) begin n_fail++; $display("FAIL reset_release got=%b want=%b", oa, expect_of(ma)); end
  endtask

  task automatic test_basic();
    int c = 0, r1 = -1, r2 = -1, done_c = -1;
    logic prev;
    logic [3:0] oa;
    a_val = 1; a_per = 8'd3; a_dur = 8'd2; a_tick = 0;
    prev = a_spk;
    while (done_c < 0 && c < 200) begin
      @(negedge clk);
      c++;
      a_val = 0;
      oa = {a_spk, a_busy, a_rdy, a_done};
      n_checks++;
      if (oa !== expect_of(ma)) begin n_fail++; $display("FAIL basic_cycle c=%0d got=%b want=%b", c, oa, expect_of(ma)); end
      if (a_spk && !prev) begin
        if (r1 < 0) r1 = c; else if (r2 < 0) r2 = c;
      end
      prev = a_spk;
      if (c == 41) begin
        n_checks++;
        if ({a_spk, a_busy} !== 2'b01) begin n_fail++; $display("FAIL basic_after_2nd_tick spk,busy got=%b want=01", {a_spk, a_busy}); end
      end
      if (a_done) done_c = c;
      a_tick = (c % 20 == 0);
    end
    a_tick = 0;
    n_checks++;
    if (r1 != 5) begin n_fail++; $display("FAIL basic_first_rise got=%0d want=5", r1); end
    n_checks++;
    if (r2 - r1 != 8) begin n_fail++; $display("FAIL basic_period got=%0d want=8", r2 - r1); end
    n_checks++;
    if (done_c != 61) begin n_fail++; $display("FAIL basic_done_cycle got=%0d want=61 (-1 is timeout)", done_c); end
  endtask

  task automatic test_rest();
    int busy_cnt = 0, done_cnt = 0, spk_ones = 0;
    logic [3:0] oa;
    a_val = 1; a_per = 8'd0; a_dur = 8'd3; a_tick = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      a_val = 0;
      oa = {a_spk, a_busy, a_rdy, a_done};
      n_checks++;
      if (oa !== expect_of(ma)) begin n_fail++; $display("FAIL rest_cycle c=%0d got=%b want=%b", c, oa, expect_of(ma)); end
      busy_cnt += int'(a_busy);
      done_cnt += int'(a_done);
      spk_ones += int'(a_spk);
      a_tick = (c % 5 == 0);
    end
    a_tick = 0;
    n_checks++;
    if (spk_ones != 0) begin n_fail++; $display("FAIL rest_spk_high_cycles got=%0d want=0", spk_ones); end
    n_checks++;
    if (busy_cnt != 20) begin n_fail++; $display("FAIL rest_busy_cycles got=%0d want=20", busy_cnt); end
    n_checks++;
    if (done_cnt != 1) begin n_fail++; $display("FAIL rest_done_pulses got=%0d want=1", done_cnt); end
  endtask

  task automatic test_long();
    int busy_cnt = 0, done_cnt = 0, rises = 0;
    logic prev;
    logic [3:0] oa;
    a_val = 1; a_per = 8'd1; a_dur = 8'd0; a_tick = 1;
    prev = a_spk;
    for (int c = 1; c <= 270; c++) begin
      @(negedge clk);
      a_val = 0;
      oa = {a_spk, a_busy, a_rdy, a_done};
      n_checks++;
      if (oa !== expect_of(ma)) begin n_fail++; $display("FAIL long_cycle c=%0d got=%b want=%b", c, oa, expect_of(ma)); end
      busy_cnt += int'(a_busy);
      done_cnt += int'(a_done);
      if (a_spk && !prev) rises++;
      prev = a_spk;
    end
    a_tick = 0;
    n_checks++;
    if (busy_cnt != 257) begin n_fail++; $display("FAIL long_busy_cycles got=%0d want=257", busy_cnt); end
    n_checks++;
    if (rises != 64) begin n_fail++; $display("FAIL long_spk_rises got=%0d want=64", rises); end
    n_checks++;
    if (done_cnt != 1) begin n_fail++; $display("FAIL long_done_pulses got=%0d want=1", done_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] pers [3] = '{8'd2, 8'd1, 8'd0};
    logic [7:0] durs [3] = '{8'd2, 8'd1, 8'd3};
    int idx = 0, c = 0, done_cnt = 0, acc_at_done = 0;
    logic acc, pend_next;
    logic [3:0] ob;
    b_val = 1; b_per = pers[0]; b_dur = durs[0]; b_tick = 1;
    acc = b_rdy;
    pend_next = 0;
    while (done_cnt < 3 && c < 300) begin
      @(negedge clk);
      c++;
      if (acc) begin
        idx++;
        acc = 0;
        if (idx < 3) begin b_per = pers[idx]; b_dur = durs[idx]; end
        else b_val = 0;
      end
      ob = {b_spk, b_busy, b_rdy, b_done};
      n_checks++;
      if (ob !== expect_of(mb)) begin n_fail++; $display("FAIL b2b_cycle c=%0d got=%b want=%b", c, ob, expect_of(mb)); end
      if (b_busy) begin
        n_checks++;
        if (b_rdy !== 1'b0) begin n_fail++; $display("FAIL b2b_rdy_while_busy c=%0d got=%b want=0", c, b_rdy); end
      end
      if (pend_next) begin
        n_checks++;
        if (b_busy !== 1'b1) begin n_fail++; $display("FAIL b2b_idle_gap c=%0d busy got=%b want=1", c, b_busy); end
      end
      pend_next = 0;
      if (b_done) begin
        done_cnt++;
        if (b_val && b_rdy) begin acc_at_done++; pend_next = 1; end
      end
      if (b_val && b_rdy) acc = 1;
      b_tick = (c % 3 == 0);
    end
    b_val = 0; b_tick = 0;
    n_checks++;
    if (done_cnt != 3) begin n_fail++; $display("FAIL b2b_done_pulses got=%0d want=3 (timeout if low)", done_cnt); end
    n_checks++;
    if (acc_at_done != 2) begin n_fail++; $display("FAIL b2b_accept_in_done_cycle got=%0d want=2", acc_at_done); end
  endtask

  task automatic test_coincide();
    logic [3:0] oa;
    a_val = 1; a_per = 8'd1; a_dur = 8'd1; a_tick = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      a_val = 0;
      oa = {a_spk, a_busy, a_rdy, a_done};
      n_checks++;
      if (oa !== expect_of(ma)) begin n_fail++; $display("FAIL coincide_cycle c=%0d got=%b want=%b", c, oa, expect_of(ma)); end
      if (c == 3) begin
        n_checks++;
        if ({a_spk, a_busy} !== 2'b01) begin n_fail++; $display("FAIL coincide_end_wins spk,busy got=%b want=01", {a_spk, a_busy}); end
      end
      a_tick = (c == 2) || (c == 5);
    end
    a_tick = 0;
  endtask

  task automatic test_reset_mid();
    int c = 0, done_cnt = 0;
    logic [3:0] oa;
    a_val = 1; a_per = 8'd2; a_dur = 8'd5; a_tick = 0;
    while (a_spk !== 1'b1 && c < 50) begin
      @(negedge clk);
      c++;
      a_val = 0;
      a_tick = (c % 10 == 0);
    end
    n_checks++;
    if (a_spk !== 1'b1) begin n_fail++; $display("FAIL rstmid_spk_high_timeout got=%b want=1", a_spk); end
    a_val = 1; a_per = 8'd4; a_dur = 8'd2;
    rst = 1;
    @(negedge clk);
    rst = 0;
    a_val = 0;
    oa = {a_spk, a_busy, a_rdy, a_done};
    n_checks++;
    if (oa !== 4'b0010) begin n_fail++; $display("FAIL rstmid_after_rst got=%b want=0010", oa); end
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      oa = {a_spk, a_busy, a_rdy, a_done};
      n_checks++;
      if (oa !== expect_of(ma)) begin n_fail++; $display("FAIL rstmid_cycle i=%0d got=%b want=%b", i, oa, expect_of(ma)); end
      done_cnt += int'(a_done);
      a_tick = (i % 4 == 0);
    end
    a_tick = 0;
    n_checks++;
    if (done_cnt != 0) begin n_fail++; $display("FAIL rstmid_done_pulses got=%0d want=0", done_cnt); end
  endtask

  task automatic test_random();
    logic [3:0] oa, ob;
    for (int c = 1; c <= 2000; c++) begin
      @(negedge clk);
      oa = {a_spk, a_busy, a_rdy, a_done};
      ob = {b_spk, b_busy, b_rdy, b_done};
      n_checks++;
      if (oa !== expect_of(ma)) begin n_fail++; $display("FAIL random_a c=%0d got=%b want=%b", c, oa, expect_of(ma)); end
      n_checks++;
      if (ob !== expect_of(mb)) begin n_fail++; $display("FAIL random_b c=%0d got=%b want=%b", c, ob, expect_of(mb)); end
      rst    = ($urandom_range(0, 299) == 0);
      a_val  = 1'($urandom_range(0, 1));
      a_per  = 8'($urandom_range(0, 5));
      a_dur  = 8'($urandom_range(1, 4));
      a_tick = ($urandom_range(0, 2) == 0);
      b_val  = 1'($urandom_range(0, 1));
      b_per  = 8'($urandom_range(0, 5));
      b_dur  = 8'($urandom_range(1, 4));
      b_tick = ($urandom_range(0, 2) == 0);
    end
    rst = 0;
    idle_inputs();
  endtask

  initial begin
    ma = '0;
    mb = '0;
    rst = 1;
    idle_inputs();
    test_reset();
    test_basic();
    test_rest();
    test_long();
    test_back_to_back();
    test_coincide();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
